div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Sequencing controller for the repeated-subtraction divider. It drives the load/update side of the quotient counter register: on each successful subtraction it pulses that register's update input, and it holds the running remainder internally. It accepts a start request with an unsigned dividend and divisor, then reports `done`, the remainder and a divide-by-zero flag. It sits between the top-level test harness and the quotient register.

## Interface
- `WIDTH`, 8, operand, remainder and `q_din` width.
- `clk` in 1: rising-edge clock for this block. The quotient register samples `q_ld`/`q_upd` on the falling edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: request a division. Sampled only in IDLE.
- `dividend` in WIDTH: unsigned dividend, captured on the accepted start.
- `divisor` in WIDTH: unsigned divisor, captured on the accepted start.
- `busy` out 1: high in LOAD and SUB.
- `done` out 1: one-cycle pulse in the DONE state.
- `dz_err` out 1: divisor was 0. Valid with `done` and held until the next accepted start.
- `rem` out WIDTH: remainder. Valid from DONE and held until the next accepted start.
- `q_ld` out 1: quotient register load strobe.
- `q_din` out WIDTH: quotient register load value. Constant 0.
- `q_upd` out 1: quotient register increment strobe.

## Operation
- States are IDLE, LOAD, SUB and DONE, held in a 2-bit registered state.
- Internal registers are R (remainder), D (divisor) and dz.
- IDLE:
  - `start` = 1 captures R←dividend, D←divisor, dz←(divisor == 0) and moves to LOAD.
  - `start` = 0 stays in IDLE.
- LOAD:
  - `q_ld` = 1 and `q_din` = 0 for exactly this cycle, so the quotient register clears on the falling edge.
  - Next state is DONE if dz, otherwise SUB.
- SUB:
  - If R ≥ D: R←R−D, `q_upd` = 1 this cycle, stay in SUB.
  - If R < D: `q_upd` = 0, go to DONE.
  - Comparison and subtraction are unsigned, WIDTH bits. R−D never underflows because it is guarded by R ≥ D.
- DONE: `done` = 1 for one cycle, then IDLE.
- `rem` = R at all times. R changes only in IDLE-capture and SUB, so `rem` holds after DONE.
- `dz_err` = dz.
- `q_ld`, `q_upd`, `busy` and `done` decode combinationally from the state and the R ≥ D compare. They are stable before the falling edge.
- `start` while not in IDLE is ignored, with no queuing.
- A new start in IDLE overwrites `rem` and `dz_err`.
- The sum of `q_upd` pulses equals the quotient ⌊dividend/divisor⌋. The block never asserts `q_ld` and `q_upd` in the same cycle.

## Timing
- Reset, on any rising edge with `rst` = 0 and from any state:
  - state→IDLE, R←0, D←0, dz←0.
  - So `busy` = `done` = `dz_err` = `q_ld` = `q_upd` = 0 and `rem` = 0.
- Reset mid-operation aborts the operation with no `done` pulse.
- Cycle numbering, with quotient N and start accepted at rising edge E0:
  - Cycle after E0: LOAD (`q_ld`).
  - Cycles after E1 … E(N): SUB with `q_upd` = 1 (N cycles).
  - Cycle after E(N+1): final SUB with `q_upd` = 0.
  - Cycle after E(N+2): DONE.
- `done` is therefore N+2 edges after the start edge. The maximum is 257 for WIDTH = 8 (255/1).
- Divide by zero: LOAD after E0, DONE after E1, `done` with `dz_err` = 1, no `q_upd`, `rem` = dividend.
- Dividend < divisor, nonzero divisor: N = 0. `done` after E2, `rem` = dividend.
- `start` held high through DONE: no new capture until IDLE is re-entered. A new operation may begin on the edge that enters IDLE+1 (back-to-back spacing of N+4 edges).

## Test plan
- 100/7: `q_ld` once, then exactly 14 `q_upd` pulses; `done` 16 edges after start; `rem` = 2, `dz_err` = 0; external quotient register reads 14.
- 5/9: zero `q_upd`; `done` 2 edges after start; `rem` = 5, quotient register 0.
- 255/1: 255 consecutive `q_upd` pulses; `done` at edge 257; `rem` = 0; quotient 255 with no wrap.
- 20/0: `q_ld` pulse, `done` one edge after LOAD; `dz_err` = 1, `rem` = 20, no `q_upd`. The next start of 9/3 clears `dz_err` and gives `rem` = 0, quotient 3.
- 200/3 with `start` re-pulsed as 50/5 mid-SUB: second start ignored; result `rem` = 2, quotient 66.
- 200/3 with `rst` = 0 for one cycle at the 10th SUB cycle: next cycle IDLE, all outputs 0, no `done`. A following 9/4 yields `rem` = 1, quotient 2.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
// Sequencing controller for a repeated-subtraction divider. It holds the
// running remainder and divisor, and drives the load/increment strobes of an
// external quotient counter that samples them on the falling clock edge.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-low reset
//   i_start     division request, sampled only in IDLE
//   i_dividend  unsigned dividend, captured on an accepted start
//   i_divisor   unsigned divisor, captured on an accepted start
//   o_busy      high in LOAD and SUB
//   o_done      one-cycle pulse in DONE
//   o_dz_err    divisor was zero; held until the next accepted start
//   o_rem       remainder; held until the next accepted start
//   o_q_ld      quotient register load strobe (LOAD only)
//   o_q_din     quotient register load value (always zero)
//   o_q_upd     quotient register increment strobe (one per subtraction)
module div_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dz_err,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_ld,
    output logic [WIDTH-1:0] o_q_din,
    output logic             o_q_upd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_dz;
    logic             w_ge;

    // Subtraction is only performed when this holds, so R-D never wraps.
    assign w_ge = (r_rem >= r_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_div   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_rem <= i_dividend;
                        r_div <= i_divisor;
                        r_dz  <= (i_divisor == '0);
                    end
                end
                S_SUB: begin
                    if (w_ge) begin
                        r_rem <= r_rem - r_div;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from registered state only, so they settle well
    // before the falling edge where the quotient register samples them.
    always_comb begin
        w_next  = r_state;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_q_ld  = 1'b0;
        o_q_upd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_busy = 1'b1;
                o_q_ld = 1'b1;
                w_next = r_dz ? S_DONE : S_SUB;
            end
            S_SUB: begin
                o_busy = 1'b1;
                if (w_ge) begin
                    o_q_upd = 1'b1;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_rem    = r_rem;
    assign o_dz_err = r_dz;
    assign o_q_din  = '0;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed testbench for div_seq_ctrl. A behavioural quotient register
// samples q_ld/q_upd on the falling edge; expected values are hand-computed.
module tb_div_seq_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy, done, dz_err, q_ld, q_upd;
    logic [WIDTH-1:0] rem, q_din;

    logic [WIDTH-1:0] qreg = '0;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_busy     (busy),
        .o_done     (done),
        .o_dz_err   (dz_err),
        .o_rem      (rem),
        .o_q_ld     (q_ld),
        .o_q_din    (q_din),
        .o_q_upd    (q_upd)
    );

    always #5 clk = ~clk;

    // External quotient counter, falling-edge sampled.
    always @(negedge clk) begin
        if (q_ld) qreg <= q_din;
        else if (q_upd) qreg <= qreg + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accepts a start at the next rising edge (E0) and watches cycles after
    // E0..E(k) at falling edges. Optionally re-pulses start at cycle inj_k,
    // or applies reset at cycle rst_k (then checks the aborted state).
    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input int inj_k, input int rst_k,
                       output int done_k, output int n_ld, output int n_upd,
                       output int n_both);
        done_k = -1; n_ld = 0; n_upd = 0; n_both = 0;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (q_ld) n_ld++;
            if (q_upd) n_upd++;
            if (q_ld && q_upd) n_both++;
            if (k == 0) begin
                chk("load_busy", busy, 1);
                chk("load_qdin", q_din, 0);
            end
            if (k == rst_k + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_qld", q_ld, 0);
                chk("abort_qupd", q_upd, 0);
                chk("abort_rem", rem, 0);
                chk("abort_dz", dz_err, 0);
                rst = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("abort_nodone", done, 0);
                end
                return;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (k == inj_k) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end
            if (k == inj_k + 1) start = 1'b0;
            if (k == rst_k) rst = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic div_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int inj_k, input int exp_q, input int exp_rem,
                            input int exp_dz, input int exp_edges);
        int dk, nl, nu, nb;
        run(a, b, inj_k, -10, dk, nl, nu, nb);
        chk({tag, "_done_edge"}, dk, exp_edges);
        chk({tag, "_rem"}, rem, exp_rem);
        chk({tag, "_dz"}, dz_err, exp_dz);
        chk({tag, "_nld"}, nl, 1);
        chk({tag, "_nupd"}, nu, exp_q);
        chk({tag, "_both"}, nb, 0);
        @(negedge clk);
        chk({tag, "_qreg"}, qreg, exp_q);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_rem_hold"}, rem, exp_rem);
        chk({tag, "_dz_hold"}, dz_err, exp_dz);
    endtask

    initial begin
        int dk, nl, nu, nb;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz_err, 0);
        chk("rst_qld", q_ld, 0);
        chk("rst_qupd", q_upd, 0);
        chk("rst_rem", rem, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        div_case("d100_7", 8'd100, 8'd7, -10, 14, 2, 0, 16);
        div_case("d5_9", 8'd5, 8'd9, -10, 0, 5, 0, 2);
        div_case("d255_1", 8'd255, 8'd1, -10, 255, 0, 0, 257);
        div_case("d20_0", 8'd20, 8'd0, -10, 0, 20, 1, 1);
        div_case("d9_3", 8'd9, 8'd3, -10, 3, 0, 0, 5);
        // Mid-SUB re-start must be ignored.
        div_case("d200_3_inj", 8'd200, 8'd3, 5, 66, 2, 0, 68);

        // Reset at the 10th SUB cycle aborts with no done pulse.
        run(8'd200, 8'd3, -10, 10, dk, nl, nu, nb);
        chk("abort_dk", dk, -1);
        chk("abort_nupd", nu, 10);
        div_case("d9_4", 8'd9, 8'd4, -10, 2, 1, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
